// File: rtl/cfg_frame_loader.sv
// Parses UART host frames (sync, cmd, payload, csum) into writes on the channel-parameter RAM port.
// Outputs register on the edge that consumes a byte; no backpressure, every rx_valid byte is taken.
module cfg_frame_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         N_PARAM        = 112,
    parameter int         TIMEOUT_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] ram_in,
    output logic [7:0] ram_w_addr,
    output logic       ram_write,
    output logic       busy,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    typedef enum logic [2:0] {IDLE, CMD, LOAD, CSUM, STARTWR} state_t;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state, state_nxt;
    logic [7:0]    addr, addr_nxt;
    logic [7:0]    sum, sum_nxt;
    logic [7:0]    sum_add;
    logic          is_start, is_start_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          timing, timeout;
    logic [7:0]    ram_in_nxt, ram_w_addr_nxt;
    logic          ram_write_nxt, frame_ok_nxt, frame_err_nxt;
    logic [1:0]    err_code_nxt;

    assign sum_add = sum + rx_data;
    assign timing  = (state == CMD) || (state == LOAD) || (state == CSUM);
    // Fires on the idle edge that would bring the counter to TIMEOUT_CYCLES; a byte on that edge wins.
    assign timeout = timing && !rx_valid && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt      = state;
        addr_nxt       = addr;
        sum_nxt        = sum;
        is_start_nxt   = is_start;
        cnt_nxt        = (!timing || rx_valid) ? '0 : cnt + 1'b1;
        ram_in_nxt     = ram_in;
        ram_w_addr_nxt = ram_w_addr;
        ram_write_nxt  = 1'b1;
        frame_ok_nxt   = 1'b0;
        frame_err_nxt  = 1'b0;
        err_code_nxt   = err_code;

        case (state)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) state_nxt = CMD;
            end
            CMD: begin
                if (rx_valid) begin
                    case (rx_data)
                        8'h01: begin
                            state_nxt    = LOAD;
                            addr_nxt     = 8'(N_PARAM);
                            sum_nxt      = 8'h01;
                            is_start_nxt = 1'b0;
                        end
                        8'h02: begin
                            state_nxt    = CSUM;
                            sum_nxt      = 8'h02;
                            is_start_nxt = 1'b1;
                        end
                        default: begin
                            state_nxt     = IDLE;
                            frame_err_nxt = 1'b1;
                            err_code_nxt  = 2'd1;
                        end
                    endcase
                end
            end
            LOAD: begin
                if (rx_valid) begin
                    ram_in_nxt     = rx_data;
                    ram_w_addr_nxt = addr;
                    ram_write_nxt  = 1'b0;
                    sum_nxt        = sum_add;
                    addr_nxt       = addr - 8'd1;
                    if (addr == 8'd1) state_nxt = CSUM;
                end
            end
            CSUM: begin
                if (rx_valid) begin
                    if (sum_add != 8'd0) begin
                        state_nxt     = IDLE;
                        frame_err_nxt = 1'b1;
                        err_code_nxt  = 2'd2;
                    end else if (is_start) begin
                        // Start write issues here; frame_ok follows from STARTWR.
                        state_nxt      = STARTWR;
                        ram_in_nxt     = 8'hFF;
                        ram_w_addr_nxt = 8'd0;
                        ram_write_nxt  = 1'b0;
                    end else begin
                        state_nxt    = IDLE;
                        frame_ok_nxt = 1'b1;
                    end
                end
            end
            STARTWR: begin
                state_nxt    = IDLE;
                frame_ok_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        if (timeout) begin
            state_nxt     = IDLE;
            frame_err_nxt = 1'b1;
            err_code_nxt  = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= 8'd0;
            sum        <= 8'd0;
            is_start   <= 1'b0;
            cnt        <= '0;
            ram_in     <= 8'd0;
            ram_w_addr <= 8'd0;
            ram_write  <= 1'b1;
            busy       <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= 2'd0;
        end else begin
            state      <= state_nxt;
            addr       <= addr_nxt;
            sum        <= sum_nxt;
            is_start   <= is_start_nxt;
            cnt        <= cnt_nxt;
            ram_in     <= ram_in_nxt;
            ram_w_addr <= ram_w_addr_nxt;
            ram_write  <= ram_write_nxt;
            busy       <= (state_nxt != IDLE);
            frame_ok   <= frame_ok_nxt;
            frame_err  <= frame_err_nxt;
            err_code   <= err_code_nxt;
        end
    end

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Self-checking bench for cfg_frame_loader: directed frames plus randomized streams scored against a frame-level model.
module tb_cfg_frame_loader;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int NP = 112;
    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] ram_in, ram_w_addr;
    logic       ram_write, busy, frame_ok, frame_err;
    logic [1:0] err_code;

    cfg_frame_loader #(.SYNC_BYTE(SYNC), .N_PARAM(NP), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .ram_in(ram_in), .ram_w_addr(ram_w_addr), .ram_write(ram_write),
        .busy(busy), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int tests_run = 0, tests_failed = 0;
    logic [15:0] wr_q[$], exp_wr[$];
    logic [7:0]  stim_q[$];
    int          idle_q[$];
    int          ok_cnt, err_cnt, exp_ok, exp_err;
    logic [1:0]  exp_code = 2'd0;

    // Observed RAM writes and status pulses, one sample per cycle.
    always @(negedge clk) begin
        if (ram_write === 1'b0) wr_q.push_back({ram_w_addr, ram_in});
        if (frame_ok === 1'b1) ok_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic send(input logic [7:0] b, input int idle);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (idle) @(negedge clk);
    endtask

    task automatic clear();
        wr_q.delete(); exp_wr.delete(); stim_q.delete(); idle_q.delete();
        ok_cnt = 0; err_cnt = 0; exp_ok = 0; exp_err = 0;
    endtask

    task automatic add(input logic [7:0] b, input int idle);
        stim_q.push_back(b);
        idle_q.push_back(idle);
    endtask

    task automatic add_load(input bit good, input int pace);
        logic [7:0] b, s;
        add(SYNC, pace); add(8'h01, pace);
        s = 8'h01;
        for (int k = 0; k < NP; k++) begin
            b = 8'($urandom);
            add(b, pace);
            s = s + b;
        end
        b = 8'h00 - s;
        if (!good) b = b ^ 8'($urandom_range(1, 255));
        add(b, pace);
    endtask

    task automatic play();
        for (int i = 0; i < stim_q.size(); i++) send(stim_q[i], idle_q[i]);
        repeat (4) @(negedge clk);
    endtask

    // Frame-level reference: walks the byte list by position, ignoring timing.
    task automatic model_run();
        int i = 0;
        int n = stim_q.size();
        logic [7:0] s, c;
        while (i < n) begin
            if (stim_q[i] != SYNC) begin
                i++;
                continue;
            end
            if (i + 1 >= n) break;
            c = stim_q[i+1];
            i += 2;
            if (c == 8'h01) begin
                if (i + NP >= n) break;
                s = 8'h01;
                for (int k = 0; k < NP; k++) begin
                    exp_wr.push_back({8'(NP - k), stim_q[i+k]});
                    s = s + stim_q[i+k];
                end
                i += NP;
                s = s + stim_q[i];
                if (s == 8'd0) exp_ok++;
                else begin exp_err++; exp_code = 2'd2; end
                i++;
            end else if (c == 8'h02) begin
                if (i >= n) break;
                s = 8'h02 + stim_q[i];
                if (s == 8'd0) begin exp_wr.push_back(16'h00FF); exp_ok++; end
                else begin exp_err++; exp_code = 2'd2; end
                i++;
            end else begin
                exp_err++;
                exp_code = 2'd1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        tests_run++;
        if (ram_write !== 1'b1 || ram_in !== 8'h00 || ram_w_addr !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_ram: write=%b in=%h addr=%h want 1/00/00", ram_write, ram_in, ram_w_addr);
        end
        tests_run++;
        if (busy !== 1'b0 || frame_ok !== 1'b0 || frame_err !== 1'b0 || err_code !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_status: busy=%b ok=%b err=%b code=%0d want 0/0/0/0", busy, frame_ok, frame_err, err_code);
        end
        rst = 1'b0;
        clear();
    endtask

    task automatic test_load();
        int bad = 0;
        clear();
        send(SYNC, 3); send(8'h01, 3);
        for (int k = 0; k < NP; k++) begin
            exp_wr.push_back({8'(NP - k), 8'(k + 1)});
            send(8'(k + 1), 0);
            if (k == 0) begin
                tests_run++;
                if (ram_write !== 1'b0 || ram_w_addr !== 8'd112 || ram_in !== 8'h01 || busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL load_first_strobe: write=%b addr=%0d in=%h busy=%b want 0/112/01/1", ram_write, ram_w_addr, ram_in, busy);
                end
            end
            repeat (3) @(negedge clk);
        end
        send(8'h47, 0);
        tests_run++;
        if (frame_ok !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_ok_timing: ok=%b busy=%b want 1/0", frame_ok, busy);
        end
        repeat (3) @(negedge clk);
        foreach (exp_wr[i]) if (i >= wr_q.size() || wr_q[i] !== exp_wr[i]) bad++;
        tests_run++;
        if (wr_q.size() != exp_wr.size() || bad != 0) begin
            tests_failed++;
            $display("FAIL load_writes: got %0d writes (%0d wrong) want %0d", wr_q.size(), bad, exp_wr.size());
        end
        tests_run++;
        if (ok_cnt != 1 || err_cnt != 0 || err_code !== 2'd0) begin
            tests_failed++;
            $display("FAIL load_status: ok=%0d err=%0d code=%0d want 1/0/0", ok_cnt, err_cnt, err_code);
        end
    endtask

    task automatic test_start();
        clear();
        send(SYNC, 0);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_busy_rise: busy=%b want 1", busy);
        end
        send(8'h02, 0); send(8'hFE, 0);
        tests_run++;
        if (ram_write !== 1'b0 || ram_w_addr !== 8'h00 || ram_in !== 8'hFF || frame_ok !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_strobe: write=%b addr=%h in=%h ok=%b want 0/00/FF/0", ram_write, ram_w_addr, ram_in, frame_ok);
        end
        @(negedge clk);
        tests_run++;
        if (frame_ok !== 1'b1 || busy !== 1'b0 || ram_write !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_ok: ok=%b busy=%b write=%b want 1/0/1", frame_ok, busy, ram_write);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (wr_q.size() != 1 || ok_cnt != 1 || (wr_q.size() == 1 && wr_q[0] !== 16'h00FF)) begin
            tests_failed++;
            $display("FAIL start_writes: got %0d writes, ok=%0d want 1 write 00<-FF, ok=1", wr_q.size(), ok_cnt);
        end
    endtask

    task automatic test_bad_csum();
        int bad = 0;
        clear();
        add(SYNC, 3); add(8'h02, 3); add(8'h00, 3);
        add(SYNC, 3); add(8'h02, 3); add(8'hFE, 3);
        model_run(); play();
        foreach (exp_wr[i]) if (i >= wr_q.size() || wr_q[i] !== exp_wr[i]) bad++;
        tests_run++;
        if (wr_q.size() != exp_wr.size() || bad != 0) begin
            tests_failed++;
            $display("FAIL bad_csum_writes: got %0d writes (%0d wrong) want %0d", wr_q.size(), bad, exp_wr.size());
        end
        tests_run++;
        if (ok_cnt != exp_ok || err_cnt != exp_err || err_code !== exp_code) begin
            tests_failed++;
            $display("FAIL bad_csum_status: ok=%0d/%0d err=%0d/%0d code=%0d/%0d", ok_cnt, exp_ok, err_cnt, exp_err, err_code, exp_code);
        end
    endtask

    task automatic test_bad_cmd();
        int bad = 0;
        clear();
        send(SYNC, 0); send(8'h07, 0);
        tests_run++;
        if (frame_err !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bad_cmd_pulse: err=%b code=%0d busy=%b want 1/1/0", frame_err, err_code, busy);
        end
        exp_err = 1; exp_code = 2'd1;
        add(8'h33, 3); add(8'h01, 3);
        add(SYNC, 3); add(8'h02, 3); add(8'hFE, 3);
        model_run(); play();
        foreach (exp_wr[i]) if (i >= wr_q.size() || wr_q[i] !== exp_wr[i]) bad++;
        tests_run++;
        if (wr_q.size() != exp_wr.size() || bad != 0) begin
            tests_failed++;
            $display("FAIL bad_cmd_writes: got %0d writes (%0d wrong) want %0d", wr_q.size(), bad, exp_wr.size());
        end
        tests_run++;
        if (ok_cnt != exp_ok || err_cnt != exp_err || err_code !== exp_code) begin
            tests_failed++;
            $display("FAIL bad_cmd_status: ok=%0d/%0d err=%0d/%0d code=%0d/%0d", ok_cnt, exp_ok, err_cnt, exp_err, err_code, exp_code);
        end
    endtask

    task automatic test_timeout();
        int bad = 0;
        logic [7:0] b;
        clear();
        send(SYNC, 3); send(8'h01, 3);
        for (int k = 0; k < 10; k++) begin
            b = 8'($urandom);
            exp_wr.push_back({8'(NP - k), b});
            send(b, (k == 9) ? 0 : 3);
        end
        repeat (TO - 1) @(negedge clk);
        tests_run++;
        if (frame_err !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_early: err=%b busy=%b want 0/1", frame_err, busy);
        end
        @(negedge clk);
        tests_run++;
        if (frame_err !== 1'b1 || err_code !== 2'd3 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_fire: err=%b code=%0d busy=%b want 1/3/0", frame_err, err_code, busy);
        end
        exp_code = 2'd3;
        repeat (3) @(negedge clk);
        foreach (exp_wr[i]) if (i >= wr_q.size() || wr_q[i] !== exp_wr[i]) bad++;
        tests_run++;
        if (wr_q.size() != 10 || bad != 0 || err_cnt != 1) begin
            tests_failed++;
            $display("FAIL timeout_writes: got %0d writes (%0d wrong) err=%0d want 10 writes, err=1", wr_q.size(), bad, err_cnt);
        end
        clear(); bad = 0;
        add_load(1'b1, 3);
        model_run(); play();
        foreach (exp_wr[i]) if (i >= wr_q.size() || wr_q[i] !== exp_wr[i]) bad++;
        tests_run++;
        if (wr_q.size() != exp_wr.size() || bad != 0 || ok_cnt != 1 || err_cnt != 0 || err_code !== exp_code) begin
            tests_failed++;
            $display("FAIL timeout_recover: writes=%0d/%0d wrong=%0d ok=%0d err=%0d code=%0d/%0d", wr_q.size(), exp_wr.size(), bad, ok_cnt, err_cnt, err_code, exp_code);
        end
    endtask

    task automatic test_terminal_count();
        int bad = 0;
        clear();
        add_load(1'b1, 0);
        for (int i = 0; i < 5; i++) idle_q[i] = TO - 1;
        model_run(); play();
        foreach (exp_wr[i]) if (i >= wr_q.size() || wr_q[i] !== exp_wr[i]) bad++;
        tests_run++;
        if (wr_q.size() != exp_wr.size() || bad != 0 || ok_cnt != 1 || err_cnt != 0) begin
            tests_failed++;
            $display("FAIL terminal_count: writes=%0d/%0d wrong=%0d ok=%0d err=%0d want ok=1 err=0", wr_q.size(), exp_wr.size(), bad, ok_cnt, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        clear();
        add_load(1'b1, 0);
        add_load(1'b1, 0);
        model_run(); play();
        foreach (exp_wr[i]) if (i >= wr_q.size() || wr_q[i] !== exp_wr[i]) bad++;
        tests_run++;
        if (wr_q.size() != 2 * NP || bad != 0 || ok_cnt != 2 || err_cnt != 0) begin
            tests_failed++;
            $display("FAIL back_to_back: writes=%0d want %0d wrong=%0d ok=%0d err=%0d", wr_q.size(), 2 * NP, bad, ok_cnt, err_cnt);
        end
    endtask

    task automatic test_random();
        int bad;
        int kind;
        for (int r = 0; r < 4; r++) begin
            clear(); bad = 0;
            for (int f = 0; f < 5; f++) begin
                kind = $urandom_range(0, 5);
                if ($urandom_range(0, 1) == 1) add(8'($urandom_range(0, 8'hA4)), $urandom_range(1, 3));
                if (kind <= 1) add_load(kind == 0, $urandom_range(1, 3));
                else if (kind <= 4) begin
                    add(SYNC, 1); add(8'h02, 1);
                    add((kind == 4) ? 8'($urandom_range(0, 8'hFD)) : 8'hFE, 2);
                end else begin
                    add(SYNC, 1); add(8'($urandom_range(3, 255)), 2);
                end
            end
            model_run(); play();
            foreach (exp_wr[i]) if (i >= wr_q.size() || wr_q[i] !== exp_wr[i]) bad++;
            tests_run++;
            if (wr_q.size() != exp_wr.size() || bad != 0) begin
                tests_failed++;
                $display("FAIL random_writes[%0d]: got %0d writes (%0d wrong) want %0d", r, wr_q.size(), bad, exp_wr.size());
            end
            tests_run++;
            if (ok_cnt != exp_ok || err_cnt != exp_err || err_code !== exp_code) begin
                tests_failed++;
                $display("FAIL random_status[%0d]: ok=%0d/%0d err=%0d/%0d code=%0d/%0d", r, ok_cnt, exp_ok, err_cnt, exp_err, err_code, exp_code);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int bad = 0;
        logic [7:0] b;
        clear();
        send(SYNC, 0); send(8'h01, 0);
        for (int k = 0; k < 50; k++) begin
            b = 8'($urandom_range(0, 8'hA4));
            exp_wr.push_back({8'(NP - k), b});
            send(b, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_code = 2'd0;
        tests_run++;
        if (ram_write !== 1'b1 || busy !== 1'b0 || err_code !== 2'd0 || frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_status: write=%b busy=%b code=%0d err=%b want 1/0/0/0", ram_write, busy, err_code, frame_err);
        end
        for (int k = 50; k <= NP; k++) send(8'($urandom_range(0, 8'hA4)), 0);
        send(SYNC, 1); send(8'h02, 1); send(8'hFE, 1);
        repeat (4) @(negedge clk);
        exp_wr.push_back(16'h00FF);
        foreach (exp_wr[i]) if (i >= wr_q.size() || wr_q[i] !== exp_wr[i]) bad++;
        tests_run++;
        if (wr_q.size() != exp_wr.size() || bad != 0 || ok_cnt != 1 || err_cnt != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_writes: writes=%0d/%0d wrong=%0d ok=%0d err=%0d want ok=1 err=0", wr_q.size(), exp_wr.size(), bad, ok_cnt, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_start();
        test_bad_csum();
        test_bad_cmd();
        test_timeout();
        test_terminal_count();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cfg_frame_loader.md
# cfg_frame_loader

- Sits between the UART Rx byte stream and the 113-byte channel-parameter RAM.
- Parses host frames, checks each frame's checksum, and drives the RAM write port (`in`, `w_addr`, active-low `write`).
- The 112 parameter bytes go to addresses 112 down to 1. The start command (0xFF) goes to address 0 only through a dedicated start frame.
- Frame format: `SYNC_BYTE`, `cmd`, payload, `csum`. `cmd` + payload + `csum` ≡ 0 (mod 256).

## Interface

Parameters:
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `N_PARAM`, 112, parameter bytes per load frame; the first byte lands at address `N_PARAM`.
- `TIMEOUT_CYCLES`, 500000, idle cycles allowed between bytes inside a frame (10 ms at 50 MHz).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid while it is high.
- `ram_in`  out  8  byte to the RAM `in` port.
- `ram_w_addr`  out  8  address to the RAM `w_addr` port.
- `ram_write`  out  1  active-low write strobe to the RAM `write` port.
- `busy`  out  1  high in every state except IDLE.
- `frame_ok`  out  1  one-cycle pulse when a frame is accepted.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted.
- `err_code`  out  2  last error: 0 none, 1 bad cmd, 2 bad csum, 3 timeout. Holds until the next error or `rst`.

## Operation

- Only cycles with `rx_valid`=1 consume a byte.
- States:
  - IDLE: a byte equal to `SYNC_BYTE` → CMD. Every other byte is ignored.
  - CMD: 0x01 → LOAD, with addr=`N_PARAM` and sum=0x01. 0x02 → CSUM, with sum=0x02. Any other value → error 1, back to IDLE.
  - LOAD: each byte produces one write of that byte to the current addr. Then sum+=byte and addr-=1. After the write to addr 1 → CSUM.
  - CSUM:
    - (sum+byte)[7:0]≠0 → error 2, back to IDLE.
    - Correct sum on a load frame → `frame_ok`, back to IDLE.
    - Correct sum on a start frame → STARTWR.
  - STARTWR: one write of 0xFF to address 0, then `frame_ok`, back to IDLE.
- Load frames never write address 0.
- Parameter bytes are written before the checksum is checked. A bad checksum therefore leaves those writes in place, suppresses the start write, and raises error 2. The host must resend the frame.
- A `SYNC_BYTE` value inside the payload or in the csum position is treated as data; there is no resync.
- Timeout:
  - A counter runs in CMD, LOAD and CSUM.
  - It clears on every consumed byte and on entry to those states.
  - Reaching `TIMEOUT_CYCLES` → error 3, back to IDLE, and no further writes.
  - If `rx_valid` arrives in the same cycle as the terminal count, the byte wins and the counter clears.
- On any error: `frame_err` pulses for one cycle and `err_code` updates in the same cycle.
- Reset values:
  - `ram_write`=1, `ram_in`=0, `ram_w_addr`=0.
  - `busy`=0, `frame_ok`=0, `frame_err`=0, `err_code`=0.
  - State=IDLE, counter=0, sum=0.
- `rst` in mid-frame aborts the frame: `ram_write` is 1 from the next edge, and no error is reported.

## Timing

- All outputs are registered.
- A byte consumed at edge N → `ram_in`/`ram_w_addr` are valid and `ram_write`=0 from edge N+1 for exactly one cycle. The RAM samples the write at edge N+2.
- Back-to-back `rx_valid` on consecutive cycles is supported: one write strobe per byte, never merged.
- STARTWR: `ram_write`=0 in the cycle after the csum byte is consumed. `frame_ok` pulses in the following cycle.
- Load frame: `frame_ok` pulses one cycle after the csum byte is consumed.
- `frame_err` pulses one cycle after the offending byte is consumed, or after the timeout terminal count.
- `busy` rises one cycle after the sync byte is consumed and falls in the same cycle as the `frame_ok`/`frame_err` pulse.

## Test plan

- Load frame (per-byte pacing applies to all byte-stream tests): A5 01, then bytes 0x01..0x70, then 0x47, one byte every 4 cycles → exactly 112 strobes, addr 112←0x01 … addr 1←0x70, one `frame_ok`, no write to addr 0, `err_code`=0.
- Start frame: A5 02 FE → one write, addr 0 ← 0xFF; `frame_ok`; total of one strobe.
- Bad checksum on a start frame: A5 02 00 → no write, `frame_err` pulse, `err_code`=2; a following A5 02 FE is accepted.
- Bad command: A5 07 → `frame_err`, `err_code`=1, `busy`=0. Stray bytes 0x33 0x01 are ignored; the next A5 is accepted.
- Timeout: A5 01 plus 10 bytes, then silence for `TIMEOUT_CYCLES` → `err_code`=3 and exactly 10 strobes. A subsequent full load frame is accepted. Also drive `rx_valid` exactly at the terminal count → no timeout.
- Reset mid-frame:
  - Send 50 payload bytes back-to-back, then assert `rst` for 1 cycle.
  - Required: `ram_write`=1 after the reset edge, `busy`=0, `err_code`=0.
  - Remaining payload bytes cause no writes until an A5 is received.
